// File: rtl/spi_mult_ctrl.sv
// SPI command front end and sequential unsigned shift-add multiplier.
// Received frames carry a 2-bit opcode in the top bits and operand data in
// the low bits. The product is returned on miso_reg_data for the next transfer.
module spi_mult_ctrl #(
    parameter int FRAME_WIDTH = 16,
    parameter int OP_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FRAME_WIDTH-1:0] mosi_reg_data,
    input  logic                   rx_valid,
    output logic                   spi_start,
    output logic [FRAME_WIDTH-1:0] miso_reg_data,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int PROD_W = 2 * OP_WIDTH;
    localparam int CNT_W  = $clog2(OP_WIDTH + 1);

    localparam logic [1:0] OPC_NOP    = 2'b00;
    localparam logic [1:0] OPC_LOAD_A = 2'b01;
    localparam logic [1:0] OPC_LOAD_B = 2'b10;
    localparam logic [1:0] OPC_START  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OP_WIDTH-1:0]    op_a_q, op_a_d;
    logic [OP_WIDTH-1:0]    op_b_q, op_b_d;
    logic [PROD_W-1:0]      acc_q, acc_d;
    logic [PROD_W-1:0]      mcand_q, mcand_d;
    logic [OP_WIDTH-1:0]    mplier_q, mplier_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_WIDTH-1:0] miso_q, miso_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;

    logic [1:0]             opcode;
    logic [OP_WIDTH-1:0]    data;
    logic                   unused_frame_bits;

    assign opcode = mosi_reg_data[FRAME_WIDTH-1:FRAME_WIDTH-2];
    assign data   = mosi_reg_data[OP_WIDTH-1:0];
    // Middle frame bits are don't-care; fold them so they are visibly consumed.
    assign unused_frame_bits = ^mosi_reg_data;

    // Status outputs decode straight from registered state, never from rx_valid.
    assign spi_start     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign miso_reg_data = miso_q;
    assign done          = done_q;
    assign overrun       = overrun_q;

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            miso_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            miso_q    <= miso_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: frame decode in IDLE, one shift-add step per MULT cycle,
    // product publish in DONE. Frames arriving while busy are dropped.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        miso_d    = miso_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (opcode)
                        OPC_NOP: begin
                            if (data[0]) begin
                                overrun_d = 1'b0;
                            end
                        end
                        OPC_LOAD_A: op_a_d = data;
                        OPC_LOAD_B: op_b_d = data;
                        OPC_START: begin
                            acc_d    = '0;
                            mcand_d  = PROD_W'(op_a_q);
                            mplier_d = op_b_q;
                            cnt_d    = '0;
                            state_d  = ST_MULT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MULT: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(OP_WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                miso_d  = FRAME_WIDTH'(acc_q);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_mult_ctrl.sv
// Randomized self-checking bench for spi_mult_ctrl against an arithmetic model.
module tb_spi_mult_ctrl;

    localparam int FW  = 16;
    localparam int OPW = 8;

    logic          clk;
    logic          reset;
    logic [FW-1:0] mosi_reg_data;
    logic          rx_valid;
    logic          spi_start;
    logic [FW-1:0] miso_reg_data;
    logic          busy;
    logic          done;
    logic          overrun;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: operands, sticky flag and last product.
    int m_a;
    int m_b;
    int m_ovr;
    int m_prod;

    spi_mult_ctrl #(.FRAME_WIDTH(FW), .OP_WIDTH(OPW)) dut (
        .clk           (clk),
        .reset         (reset),
        .mosi_reg_data (mosi_reg_data),
        .rx_valid      (rx_valid),
        .spi_start     (spi_start),
        .miso_reg_data (miso_reg_data),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_spi_start"}, 32'(spi_start), 1);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, "_miso"}, 32'(miso_reg_data), 32'(m_prod));
    endtask

    function automatic logic [FW-1:0] mk_frame(input int opc, input int dat);
        logic [FW-1:0] f;
        f = FW'($urandom);
        f[FW-1:FW-2] = 2'(opc);
        f[OPW-1:0]   = OPW'(dat);
        return f;
    endfunction

    // Send one non-START frame while idle and update the model.
    task automatic send_idle(input logic [FW-1:0] f);
        @(negedge clk);
        mosi_reg_data = f;
        rx_valid      = 1'b1;
        @(negedge clk);
        rx_valid      = 1'b0;
        mosi_reg_data = FW'($urandom);
        case (int'(f[FW-1:FW-2]))
            0: if (f[0]) m_ovr = 0;
            1: m_a = int'(f[OPW-1:0]);
            2: m_b = int'(f[OPW-1:0]);
            default: ;
        endcase
        $display("frame 0x%04h -> a=0x%02h b=0x%02h ovr=%0d", f, m_a, m_b, m_ovr);
        chk_idle("frame");
    endtask

    // Issue START; optionally inject a frame inj_at cycles after the START edge.
    task automatic run_start(input int inj_at, input logic [FW-1:0] inj_frame);
        int exp_prod;
        int busy_cnt;
        int done_cnt;
        int done_at;
        exp_prod = (m_a * m_b) & 32'hFFFF;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        mosi_reg_data = mk_frame(3, $urandom);
        rx_valid      = 1'b1;
        for (int i = 1; i <= OPW + 5; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i - 1;
                chk("prod_at_done", 32'(miso_reg_data), 32'(exp_prod));
            end else if (done_cnt == 0) begin
                chk("miso_hold", 32'(miso_reg_data), 32'(m_prod));
            end
            if (inj_at > 0 && i == inj_at + 1) begin
                m_ovr = 1;
                chk("overrun_set", 32'(overrun), 1);
            end
            if (i == inj_at) begin
                mosi_reg_data = inj_frame;
                rx_valid      = 1'b1;
            end
        end
        m_prod = exp_prod;
        $display("start a=0x%02h b=0x%02h -> prod=0x%04h latency=%0d inj=%0d",
                 m_a, m_b, exp_prod, done_at, inj_at);
        chk("done_count", 32'(done_cnt), 1);
        chk("done_latency", 32'(done_at), 32'(OPW + 1));
        chk("busy_cycles", 32'(busy_cnt), 32'(OPW + 1));
        chk_idle("post_start");
    endtask

    initial begin
        reset         = 1'b1;
        rx_valid      = 1'b0;
        mosi_reg_data = '0;
        m_a = 0; m_b = 0; m_ovr = 0; m_prod = 0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;

        // 1: 255*255
        send_idle(16'h40FF);
        send_idle(16'h80FF);
        run_start(0, '0);
        chk("t1_prod", 32'(miso_reg_data), 32'hFE01);

        // 2: 12*10, then repeated START reuses operands
        send_idle(16'h400C);
        send_idle(16'h800A);
        run_start(0, '0);
        chk("t2_prod", 32'(miso_reg_data), 32'h0078);
        run_start(0, '0);
        chk("t2_reuse", 32'(miso_reg_data), 32'h0078);

        // 3: zero operand, then reload A only
        send_idle(16'h4000);
        send_idle(16'h8037);
        run_start(0, '0);
        chk("t3_zero", 32'(miso_reg_data), 32'h0000);
        send_idle(16'h4001);
        run_start(0, '0);
        chk("t3_prod", 32'(miso_reg_data), 32'h0037);

        // 4: dropped frame sets overrun; NOP clears only with bit0
        run_start(3, 16'h4055);
        chk("t4_prod", 32'(miso_reg_data), 32'h0037);
        send_idle(16'h0000);
        chk("t4_ovr_kept", 32'(overrun), 1);
        send_idle(16'h0001);
        chk("t4_ovr_clr", 32'(overrun), 0);
        // START followed immediately by LOAD: LOAD dropped
        run_start(1, 16'h40AA);
        chk("t4_b2b_prod", 32'(miso_reg_data), 32'h0037);

        // 5: asynchronous reset mid-multiply
        @(negedge clk);
        mosi_reg_data = mk_frame(3, 0);
        rx_valid      = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m_a = 0; m_b = 0; m_ovr = 0; m_prod = 0;
        chk("t5_async_miso", 32'(miso_reg_data), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_spi_start", 32'(spi_start), 1);
        chk("t5_async_overrun", 32'(overrun), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < OPW + 4; i++) begin
            @(negedge clk);
            chk("t5_no_done", 32'(done), 0);
        end
        run_start(0, '0);
        chk("t5_cleared_prod", 32'(miso_reg_data), 0);

        // 6: junk upper bits ignored
        send_idle(16'h7F03);
        send_idle(16'h8005);
        run_start(0, '0);
        chk("t6_prod", 32'(miso_reg_data), 32'h000F);

        // Random mix of loads, NOPs and starts with occasional dropped frames.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: send_idle(mk_frame(1, $urandom));
                1: send_idle(mk_frame(2, $urandom));
                2: send_idle(mk_frame(0, $urandom));
                default: begin
                    if ($urandom_range(0, 2) == 0)
                        run_start($urandom_range(1, OPW + 1), FW'($urandom));
                    else
                        run_start(0, '0);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_mult_ctrl.md
Name: spi_mult_ctrl

Overview:
Command/operand front end and sequential multiplier that sits directly downstream of the SPI slave. It consumes each received 16-bit MOSI frame, qualified by the slave's one-cycle rx_valid pulse, and decodes it as an operand load or a start command. It runs an unsigned shift-add multiply and drives the product back onto the slave's miso_reg_data input for the next transfer. It also gates the slave's spi_start so new frames are invited only when the block is idle.

Parameters:
FRAME_WIDTH, 16, SPI frame width in bits; must equal the SPI slave data width.
OP_WIDTH, 8, operand width in bits; constraint 2*OP_WIDTH <= FRAME_WIDTH and OP_WIDTH <= FRAME_WIDTH-2.

Ports:
clk  input  1  system clock, the same clock as the SPI slave.
reset  input  1  asynchronous, active-high reset.
mosi_reg_data  input  FRAME_WIDTH  received frame from the SPI slave; valid only when rx_valid=1.
rx_valid  input  1  one-cycle frame-received strobe from the SPI slave.
spi_start  output  1  permits the SPI slave to begin a transfer; high only in IDLE.
miso_reg_data  output  FRAME_WIDTH  product, zero-extended; returned on the next SPI frame.
busy  output  1  high while a multiply is in progress (MULT or DONE state).
done  output  1  one-cycle pulse when a new product is on miso_reg_data.
overrun  output  1  sticky flag: a frame arrived while busy and was dropped.

Behaviour:
- Frame format: bits [FRAME_WIDTH-1:FRAME_WIDTH-2] are the opcode; bits [OP_WIDTH-1:0] are data; all other bits are ignored.
- Opcodes:
  - 00 NOP/CLR: if data bit0=1, clear overrun; otherwise no effect.
  - 01 LOAD_A: op_a <= data.
  - 10 LOAD_B: op_b <= data.
  - 11 START: begin a multiply using the current op_a and op_b.
- Reset (asynchronous, reset=1): state=IDLE; op_a, op_b, accumulator, multiplier shift register, bit counter, miso_reg_data, done, overrun all 0; busy=0; spi_start=1 (IDLE). A reset asserted mid-multiply aborts it; no done pulse follows.
- State machine has three states: IDLE, MULT, DONE.
- IDLE: on rx_valid, decode the opcode. LOAD and NOP take effect at that edge. START at edge N loads acc<=0, mcand<=op_a zero-extended to 2*OP_WIDTH, mplier<=op_b, cnt<=0, and moves to MULT.
- MULT: each cycle, if mplier[0]=1 then acc<=acc+mcand. Then mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1. When cnt==OP_WIDTH-1 the last iteration completes and the state moves to DONE. MULT lasts exactly OP_WIDTH cycles (edges N+1..N+OP_WIDTH).
- DONE: at edge N+OP_WIDTH+1, miso_reg_data <= zero-extended acc, done <= 1 for that one cycle, state <= IDLE.
- Latency: done is high in the cycle following edge N+OP_WIDTH+1, i.e. OP_WIDTH+1 cycles after the START-sampling edge (9 for the defaults).
- Arithmetic: unsigned, with no overflow. The product fits in 2*OP_WIDTH bits and the upper FRAME_WIDTH-2*OP_WIDTH bits of miso_reg_data are always 0.
- miso_reg_data holds its value until the next DONE; it is never cleared by LOAD or NOP.
- busy = (state != IDLE); spi_start = (state == IDLE). Both are registered/decoded from state with no combinational path from rx_valid.
- Overrun: rx_valid while state is MULT or DONE drops the frame (op_a, op_b and the multiply are unaffected) and sets overrun=1 at that edge. It stays set until a NOP frame with bit0=1 is accepted in IDLE, or reset.
- A second START issued in IDLE after completion reuses the existing op_a and op_b; the registers persist.
- Back-to-back rx_valid pulses in consecutive cycles while in IDLE are each decoded. A START followed on the next cycle by a LOAD produces an overrun, and the LOAD is dropped.
- A START with op_a=0 or op_b=0 still takes the full OP_WIDTH+1 cycles and produces 0.

Test Plan:
1. Reset -> miso_reg_data=0x0000, done=0, busy=0, overrun=0, spi_start=1. Then LOAD_A 0x40FF, LOAD_B 0x80FF, START 0xC000 -> done pulses 9 cycles after START, miso_reg_data=0xFE01, busy high for exactly 9 cycles.
2. LOAD_A 0x400C, LOAD_B 0x800A, START -> 0x0078. Issue START again without reloading -> 0x0078 again, with a second done pulse.
3. LOAD_A 0x4000, LOAD_B 0x8037, START -> 0x0000 after full latency. Then LOAD_A 0x4001 alone, START -> 0x0037.
4. START, then rx_valid with 0x4055 three cycles later -> frame dropped, overrun=1, product unchanged from prior operands. Next, NOP 0x0000 -> overrun stays 1. Then NOP 0x0001 -> overrun=0.
5. Assert reset 4 cycles into MULT -> all outputs return to reset values immediately, no done pulse. After release, START -> product 0x0000, since the operands were cleared.
6. Frame 0x7F03 (opcode 01, junk upper bits) -> op_a=0x03 only. LOAD_B 0x8005, START -> 0x000F, upper bits of miso_reg_data are zero.
